// File: rtl/i2c_master_if.sv
// Request/status handshake and open-drain pad controls between an I2C register-write master and its user.
interface i2c_master_if;
    logic        req;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data;
    logic        ready;
    logic        done;
    logic        nack;
    logic        scl_oe;
    logic        sda_oe;
    logic        sda_in;

    modport master (
        input  req, reg_addr, wr_data, sda_in,
        output ready, done, nack, scl_oe, sda_oe
    );

    modport slave (
        output req, reg_addr, wr_data, sda_in,
        input  ready, done, nack, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_master.sv
// I2C register write (START, dev addr, reg hi, reg lo, data, STOP); 152 strobes accept-to-done, 44 on address NACK.
// Backpressure: ready low from acceptance until done; req ignored meanwhile and on the done clk.
module i2c_master #(
    parameter logic [6:0]  DEV_ADDR = 7'h10,
    parameter int unsigned QPB      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         strobe_400kHz,
    i2c_master_if.master bus
);
    localparam logic [1:0] Q_LAST = 2'(QPB - 1);

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  q_cnt, q_nx;
    logic [3:0]  bit_cnt, bit_nx;
    logic [1:0]  byte_cnt, byte_nx;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic        nack_q, nack_nx;
    logic        sda_q, sda_nx;
    logic        scl_c;
    logic        accept;
    logic [7:0]  cur_byte;
    logic        cur_bit;

    always_comb begin
        case (byte_cnt)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = addr_q[15:8];
            2'd2:    cur_byte = addr_q[7:0];
            default: cur_byte = data_q;
        endcase
    end

    // MSB first: bit_cnt 0 selects bit 7
    assign cur_bit = cur_byte[~bit_cnt[2:0]];
    assign accept  = bus.req && (state == IDLE);

    always_comb begin
        state_nx = state;
        q_nx     = q_cnt;
        bit_nx   = bit_cnt;
        byte_nx  = byte_cnt;
        nack_nx  = nack_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = START;
                    q_nx     = 2'd0;
                    bit_nx   = 4'd0;
                    byte_nx  = 2'd0;
                    nack_nx  = 1'b0;
                end
            end
            START: begin
                if (strobe_400kHz) begin
                    q_nx = q_cnt + 2'd1;
                    if (q_cnt == Q_LAST) state_nx = BIT;
                end
            end
            BIT: begin
                if (strobe_400kHz) begin
                    q_nx = q_cnt + 2'd1;
                    if (q_cnt == Q_LAST) begin
                        bit_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) state_nx = ACK;
                    end
                end
            end
            ACK: begin
                if (strobe_400kHz) begin
                    q_nx = q_cnt + 2'd1;
                    if (q_cnt == 2'd2 && bus.sda_in) nack_nx = 1'b1;
                    if (q_cnt == Q_LAST) begin
                        bit_nx = 4'd0;
                        if (nack_q || byte_cnt == 2'd3) begin
                            state_nx = STOP;
                        end else begin
                            state_nx = BIT;
                            byte_nx  = byte_cnt + 2'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (strobe_400kHz) begin
                    q_nx = q_cnt + 2'd1;
                    if (q_cnt == Q_LAST) state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // SDA is registered one clk behind the phase decode so it always moves after SCL has been pulled low
    always_comb begin
        scl_c  = 1'b0;
        sda_nx = 1'b0;
        case (state)
            START: sda_nx = (q_cnt >= 2'd2);
            BIT: begin
                scl_c  = (q_cnt < 2'd2);
                sda_nx = ~cur_bit;
            end
            ACK:  scl_c = (q_cnt < 2'd2);
            STOP: begin
                scl_c  = (q_cnt < 2'd2);
                sda_nx = (q_cnt != Q_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            q_cnt    <= 2'd0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
            nack_q   <= 1'b0;
            sda_q    <= 1'b0;
            addr_q   <= 16'd0;
            data_q   <= 8'd0;
        end else begin
            state    <= state_nx;
            q_cnt    <= q_nx;
            bit_cnt  <= bit_nx;
            byte_cnt <= byte_nx;
            nack_q   <= nack_nx;
            sda_q    <= sda_nx;
            if (accept) begin
                addr_q <= bus.reg_addr;
                data_q <= bus.wr_data;
            end
        end
    end

    assign bus.scl_oe = scl_c;
    assign bus.sda_oe = sda_q;
    assign bus.ready  = (state == IDLE) || (state == DONE);
    assign bus.done   = (state == DONE);
    assign bus.nack   = nack_q;
endmodule

// File: tb/tb_i2c_master.sv
// Directed + random register writes against an I2C slave/bus-monitor model that decodes SCL/SDA line levels.
module tb_i2c_master;
    localparam logic [6:0] DEV = 7'h10;

    logic clk;
    logic reset;
    logic strobe;
    int   total;
    int   bad;

    i2c_master_if bus();

    i2c_master #(.DEV_ADDR(DEV), .QPB(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .strobe_400kHz (strobe),
        .bus           (bus)
    );

    // slave/monitor shared state
    logic [7:0] got_q[$];
    int         n_start;
    int         n_stop;
    int         nack_at;
    int         byte_no;
    logic       slave_pull;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int scnt;
        scnt   = 0;
        strobe = 1'b0;
        forever begin
            @(negedge clk);
            scnt   = (scnt == 3) ? 0 : scnt + 1;
            strobe = (scnt == 0);
        end
    end

    // Open-drain bus: line high unless someone pulls. Decodes START/STOP, bits on SCL rise, ACKs as slave.
    initial begin
        logic       scl_l, sda_l, scl_p, sda_p;
        logic [7:0] shreg;
        int         bit_idx;
        scl_p = 1'b1; sda_p = 1'b1; shreg = 8'd0; bit_idx = 0;
        slave_pull = 1'b0; byte_no = 0;
        bus.sda_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            scl_l = ~bus.scl_oe;
            sda_l = ~(bus.sda_oe | slave_pull);
            if (reset) begin
                slave_pull = 1'b0;
                bit_idx    = 0;
            end else begin
                if (scl_l && scl_p && sda_l != sda_p) begin
                    if (!sda_l) begin
                        n_start++;
                        bit_idx = 0;
                        byte_no = 0;
                    end else begin
                        n_stop++;
                    end
                end
                if (scl_l && !scl_p) begin
                    if (bit_idx < 8) shreg = {shreg[6:0], sda_l};
                    bit_idx++;
                    if (bit_idx == 9) begin
                        got_q.push_back(shreg);
                        bit_idx = 0;
                        byte_no++;
                    end
                end
                if (!scl_l && scl_p) begin
                    if (slave_pull) slave_pull = 1'b0;
                    else if (bit_idx == 8 && byte_no != nack_at) slave_pull = 1'b1;
                end
            end
            scl_p = scl_l;
            sda_p = sda_l;
            bus.sda_in = ~(bus.sda_oe | slave_pull);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready_and_req(input logic [15:0] a, input logic [7:0] d);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!bus.ready && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        bus.req      = 1'b1;
        bus.reg_addr = a;
        bus.wr_data  = d;
        @(posedge clk); #1;
        chk("accept_ready_low", bus.ready, 1'b0);
        chk("accept_nack_clear", bus.nack, 1'b0);
        @(negedge clk);
        bus.req      = 1'b0;
        bus.reg_addr = 16'($urandom);
        bus.wr_data  = 8'($urandom);
    endtask

    // Expected behaviour from the protocol rules: bytes up to and including the NACKed one, 36 strobes each plus START/STOP.
    task automatic run_txn(input logic [15:0] a, input logic [7:0] d, input int nk);
        logic [7:0] exp_b[4];
        int         exp_n, exp_strb, strb, ready_bad, cyc;
        logic       exp_nack, seen_done;
        exp_b[0] = {DEV, 1'b0};
        exp_b[1] = a[15:8];
        exp_b[2] = a[7:0];
        exp_b[3] = d;
        exp_nack = (nk >= 0 && nk <= 3);
        exp_n    = exp_nack ? nk + 1 : 4;
        exp_strb = 4 + 36 * exp_n + 4;
        got_q.delete();
        n_start = 0;
        n_stop  = 0;
        nack_at = nk;
        wait_ready_and_req(a, d);
        strb = 0; ready_bad = 0; seen_done = 1'b0;
        for (cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            @(posedge clk);
            if (strobe) strb++;
            #1;
            if (bus.done) seen_done = 1'b1;
            else if (bus.ready) ready_bad++;
        end
        chk("done_seen", seen_done, 1'b1);
        chk("strobes_to_done", strb, exp_strb);
        chk("nack_at_done", bus.nack, exp_nack);
        chk("ready_at_done", bus.ready, 1'b1);
        chk("ready_low_during", ready_bad, 0);
        chk("byte_count", got_q.size(), exp_n);
        for (int i = 0; i < exp_n && i < got_q.size(); i++)
            chk($sformatf("byte%0d", i), got_q[i], exp_b[i]);
        chk("start_count", n_start, 1);
        chk("stop_count", n_stop, 1);
        @(posedge clk); #1;
        chk("done_one_clk", bus.done, 1'b0);
        chk("nack_held", bus.nack, exp_nack);
    endtask

    initial begin
        int strb, cyc, dn, acc, k, last_done_k, gap_bad;
        logic prev_ready;
        total = 0; bad = 0;
        nack_at = -1; n_start = 0; n_stop = 0;
        reset = 1'b1;
        bus.req = 1'b1;
        bus.reg_addr = 16'h0;
        bus.wr_data = 8'h0;

        // reset with req held high: nothing accepted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_oe", bus.scl_oe, 1'b0);
        chk("rst_sda_oe", bus.sda_oe, 1'b0);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_nack", bus.nack, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.req = 1'b0;

        run_txn(16'h0100, 8'h01, -1);
        run_txn(16'hA5C3, 8'h7E, 0);
        run_txn(16'h1234, 8'h56, 3);
        for (int i = 0; i < 5; i++)
            run_txn(16'($urandom), 8'($urandom), int'($urandom_range(0, 4)) - 1);

        // reset at strobe 70 of a transaction
        got_q.delete();
        nack_at = -1;
        wait_ready_and_req(16'hBEEF, 8'h42);
        strb = 0;
        cyc = 0;
        while (strb < 70 && cyc < 1000) begin
            @(posedge clk);
            if (strobe) strb++;
            cyc++;
        end
        chk("abort_reached_70", strb, 70);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_scl_oe", bus.scl_oe, 1'b0);
        chk("abort_sda_oe", bus.sda_oe, 1'b0);
        chk("abort_ready", bus.ready, 1'b1);
        chk("abort_done", bus.done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (800) begin
            @(posedge clk); #1;
            if (bus.done || bus.scl_oe || bus.sda_oe) dn++;
        end
        chk("abort_no_activity", dn, 0);

        // req held high across two transactions
        got_q.delete();
        nack_at = -1;
        @(negedge clk);
        bus.req = 1'b1;
        bus.reg_addr = 16'h0F0F;
        bus.wr_data = 8'hF0;
        acc = 0; dn = 0; k = 0; last_done_k = -10; gap_bad = 0;
        prev_ready = bus.ready;
        for (cyc = 0; cyc < 3000 && dn < 2; cyc++) begin
            @(posedge clk); #1;
            k++;
            if (prev_ready && !bus.ready) begin
                acc++;
                if (acc == 2 && k != last_done_k + 2) gap_bad++;
            end
            if (bus.done) begin
                dn++;
                last_done_k = k;
            end
            prev_ready = bus.ready;
        end
        @(negedge clk);
        bus.req = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (prev_ready && !bus.ready) acc++;
            prev_ready = bus.ready;
        end
        chk("b2b_dones", dn, 2);
        chk("b2b_accepts", acc, 2);
        chk("b2b_accept_after_done", gap_bad, 0);
        chk("b2b_bytes", got_q.size(), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter: DEV_ADDR, 7'h10, 7-bit I2C slave address of the camera sensor.
REQ-002 Parameter: QPB, 4, strobes per SCL bit, fixed at 4, giving 100kHz SCL from a 400kHz strobe.
REQ-003 clk  input  1  100MHz system clock; all logic is on its rising edge.
REQ-004 reset  input  1  one clock; synchronous active-high reset, driven from the i2c_reset sequencer output.
REQ-005 strobe_400kHz  input  1  single-cycle tick synchronous to clk; advances all bus timing.
REQ-006 req  input  1  write-request valid.
REQ-007 reg_addr  input  16  sensor register address.
REQ-008 wr_data  input  8  register write data.
REQ-009 ready  output  1  high when idle and able to accept req.
REQ-010 done  output  1  one-clk pulse at transaction end.
REQ-011 nack  output  1  error flag; valid with done and held until the next accepted req.
REQ-012 scl_oe  output  1  1 pulls SCL low; 0 releases SCL, which is high via pull-up.
REQ-013 sda_oe  output  1  1 pulls SDA low; 0 releases SDA.
REQ-014 sda_in  input  1  SDA pad level, already synchronised to clk.

Function
REQ-015 A request SHALL be accepted on a clk where req and ready are both 1; reg_addr and wr_data SHALL be captured on that edge.
REQ-016 ready SHALL drop on the accepting clk edge and stay 0 until done is pulsed.
REQ-017 While ready is 0, req SHALL be ignored.
REQ-018 All state, quarter-counter and bit-counter changes after acceptance SHALL occur only on clks where strobe_400kHz=1.
REQ-019 Each bus phase SHALL last 4 strobes, numbered q0..q3.
REQ-020 The FSM states SHALL be IDLE, START, BIT, ACK, STOP and DONE.
REQ-021 IDLE -> START on acceptance; START SHALL begin at the first strobe after acceptance.
REQ-022 START SHALL release SDA and SCL during q0-q1, then assert sda_oe=1 with SCL released during q2-q3.
REQ-023 On exiting START, scl_oe SHALL be set to 1.
REQ-024 The transaction SHALL send 4 bytes MSB first: {DEV_ADDR,1'b0}, reg_addr[15:8], reg_addr[7:0], wr_data.
REQ-025 BIT, q0: scl_oe=1 and sda_oe=~bit.
REQ-026 BIT, q1: SCL stays low.
REQ-027 BIT, q2-q3: scl_oe=0.
REQ-028 SDA SHALL change only while scl_oe=1.
REQ-029 After 8 bits the FSM SHALL enter ACK, which uses BIT timing with sda_oe=0.
REQ-030 ACK SHALL sample sda_in on the q2->q3 strobe.
REQ-031 If the ACK sample is 1 (NACK), nack SHALL be set to 1 and the FSM SHALL go to STOP, skipping the remaining bytes.
REQ-032 If the ACK sample is 0 on bytes 0-2, the FSM SHALL return to BIT for the next byte.
REQ-033 If the ACK sample is 0 on byte 3, the FSM SHALL go to STOP.
REQ-034 STOP, q0-q1: scl_oe=1 and sda_oe=1.
REQ-035 STOP, q2: scl_oe=0.
REQ-036 STOP, q3: sda_oe=0.
REQ-037 STOP -> DONE.
REQ-038 DONE SHALL pulse done for exactly 1 clk, set ready=1 on the same clk, and return to IDLE.
REQ-039 A successful transaction SHALL take exactly 4+36*4+4=152 strobes from acceptance to done.
REQ-040 A NACK on the address byte SHALL take 4+36+4=44 strobes from acceptance to done.
REQ-041 The quarter counter SHALL be 2 bits and wrap 3->0.
REQ-042 The bit counter SHALL be 4 bits and count 0..8, where 8 is the ACK slot.
REQ-043 The byte counter SHALL be 2 bits.
REQ-044 nack SHALL clear on the next accepted req.
REQ-045 req asserted in the same clk as done SHALL NOT be accepted; acceptance SHALL occur on a later clk with ready=1.
REQ-046 A strobe coinciding with the accepting clk SHALL NOT count as q0 of START.
REQ-047 sda_in SHALL be ignored outside the ACK sampling strobe.

Reset
REQ-048 With reset=1 at a clk edge, the following SHALL hold next cycle: scl_oe=0, sda_oe=0, ready=1, done=0, nack=0, FSM=IDLE, and all counters 0.
REQ-049 Reset asserted mid-transaction SHALL abort immediately, releasing both lines with no STOP generated and no done pulse.
REQ-050 While reset=1, req SHALL be ignored.

Verification
REQ-051 Reset, then req with reg_addr=16'h0100 and wr_data=8'h01, with the slave ACKing all bytes -> SDA bytes decode as 20,01,00,01; done arrives 152 strobes after acceptance; nack=0.
REQ-052 Slave NACKs the address byte -> nack=1, a STOP occurs, and done arrives at strobe 44.
REQ-053 Slave NACKs the data byte (byte 3) -> nack=1 and done arrives at strobe 152.
REQ-054 Bus monitor check over a full transaction -> SDA transitions only while SCL is low, except for the START and STOP edges.
REQ-055 reset pulsed at strobe 70 of a transaction -> scl_oe=0 and sda_oe=0 next clk, ready=1, and no done pulse.
REQ-056 req held high continuously for 2 transactions -> exactly 2 acceptances, each one clk after a done, and 2 done pulses.
